// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared constants and types for the decode stage
package decode_pkg;

    // Immediate extension modes
    typedef enum logic [1:0] {
        IMM_SEXT = 2'b00,
        IMM_ZEXT = 2'b01,
        IMM_LUI  = 2'b10,
        IMM_BR   = 2'b11
    } imm_sel_e;

    // Instruction field positions
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int IMM_LSB = 0;
    localparam int FIELD_W = 5;
    localparam int IMM_W   = 16;

endpackage

// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - register file, 2 async read ports, 1 write port, write-through
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high clear of all registers
//   we_i/waddr_i/wdata_i   write port, register 0 is never written
//   raddr_a_i/raddr_b_i    read addresses
//   rdata_a_o/rdata_b_o    read data; register 0 reads 0, a same-cycle write is forwarded
module regfile_bypass #(
    parameter  int DATA_W  = 32,
    parameter  int REG_CNT = 32,
    localparam int AW      = $clog2(REG_CNT)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_a_i,
    input  logic [AW-1:0]     raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] regs_q [REG_CNT];
    logic              wr_live;

    assign wr_live = we_i && (waddr_i != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_live) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Forward the incoming write so a decode in the writeback cycle sees new data
    assign rdata_a_o = (raddr_a_i == '0)                      ? '0      :
                       (wr_live && raddr_a_i == waddr_i)      ? wdata_i :
                                                                regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0)                      ? '0      :
                       (wr_live && raddr_b_i == waddr_i)      ? wdata_i :
                                                                regs_q[raddr_b_i];

endmodule

// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - pipelined decode stage with regfile, hazard detect and ID/EX register
//
// Ports:
//   Clk, Rst                 clock, synchronous active-high reset
//   Flush                    kill instruction in ID and in the ID/EX register
//   In_valid/In_ready/Instr  upstream handshake and instruction word
//   RF_B_sel, Imm_sel        B-port address select, immediate extension mode
//   Ex_MemRd, Ex_WrAddr      load in EX and its destination, for load-use detection
//   RF_WrEn/RF_WrAddr/RF_WrData_sel/ALU_out/MEM_out  writeback port
//   Out_valid/Out_ready      downstream handshake
//   Out_RF_A/Out_RF_B/Out_Immed/Out_rs/Out_rb        registered decoded operands
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int REG_CNT = 32,
    localparam int AW      = $clog2(REG_CNT)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Flush,
    input  logic              In_valid,
    output logic              In_ready,
    input  logic [31:0]       Instr,
    input  logic              RF_B_sel,
    input  logic [1:0]        Imm_sel,
    input  logic              Ex_MemRd,
    input  logic [AW-1:0]     Ex_WrAddr,
    input  logic              RF_WrEn,
    input  logic [AW-1:0]     RF_WrAddr,
    input  logic              RF_WrData_sel,
    input  logic [DATA_W-1:0] ALU_out,
    input  logic [DATA_W-1:0] MEM_out,
    output logic              Out_valid,
    input  logic              Out_ready,
    output logic [DATA_W-1:0] Out_RF_A,
    output logic [DATA_W-1:0] Out_RF_B,
    output logic [DATA_W-1:0] Out_Immed,
    output logic [AW-1:0]     Out_rs,
    output logic [AW-1:0]     Out_rb
);

    logic [AW-1:0]     rs_addr, rt_addr, rd_addr, rb_addr;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] wb_data, rdata_a, rdata_b, imm_sext, imm_ext;
    logic              hz, adv;
    logic              unused_opcode;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] rf_a_q, rf_a_d, rf_b_q, rf_b_d, imm_q, imm_d;
    logic [AW-1:0]     rs_q, rs_d, rb_q, rb_d;

    assign unused_opcode = ^Instr[31:26];

    assign rs_addr = Instr[RS_LSB +: AW];
    assign rt_addr = Instr[RT_LSB +: AW];
    assign rd_addr = Instr[RD_LSB +: AW];
    assign rb_addr = RF_B_sel ? rt_addr : rd_addr;
    assign imm     = Instr[IMM_LSB +: IMM_W];
    assign wb_data = RF_WrData_sel ? MEM_out : ALU_out;

    regfile_bypass #(
        .DATA_W  (DATA_W),
        .REG_CNT (REG_CNT)
    ) u_rf (
        .clk_i     (Clk),
        .rst_i     (Rst),
        .we_i      (RF_WrEn),
        .waddr_i   (RF_WrAddr),
        .wdata_i   (wb_data),
        .raddr_a_i (rs_addr),
        .raddr_b_i (rb_addr),
        .rdata_a_o (rdata_a),
        .rdata_b_o (rdata_b)
    );

    assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

    always_comb begin
        imm_ext = imm_sext;
        case (imm_sel_e'(Imm_sel))
            IMM_SEXT: imm_ext = imm_sext;
            IMM_ZEXT: imm_ext = {{(DATA_W-IMM_W){1'b0}}, imm};
            IMM_LUI:  imm_ext = DATA_W'({imm, 16'h0000});
            IMM_BR:   imm_ext = imm_sext << 2;
            default:  imm_ext = imm_sext;
        endcase
    end

    // Load-use: the loaded value is not available until after EX/MEM
    assign hz  = In_valid && Ex_MemRd && (Ex_WrAddr != '0) &&
                 ((Ex_WrAddr == rs_addr) || (Ex_WrAddr == rb_addr));
    assign adv = !valid_q || Out_ready;

    // Flush accepts and drops whatever is offered
    assign In_ready = Flush || (adv && !hz);

    always_comb begin
        valid_d = valid_q;
        rf_a_d  = rf_a_q;
        rf_b_d  = rf_b_q;
        imm_d   = imm_q;
        rs_d    = rs_q;
        rb_d    = rb_q;
        if (Flush) begin
            valid_d = 1'b0;
        end else if (adv) begin
            valid_d = In_valid && !hz;
            rf_a_d  = rdata_a;
            rf_b_d  = rdata_b;
            imm_d   = imm_ext;
            rs_d    = rs_addr;
            rb_d    = rb_addr;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_q <= 1'b0;
            rf_a_q  <= '0;
            rf_b_q  <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rb_q    <= '0;
        end else begin
            valid_q <= valid_d;
            rf_a_q  <= rf_a_d;
            rf_b_q  <= rf_b_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rb_q    <= rb_d;
        end
    end

    assign Out_valid = valid_q;
    assign Out_RF_A  = rf_a_q;
    assign Out_RF_B  = rf_b_q;
    assign Out_Immed = imm_q;
    assign Out_rs    = rs_q;
    assign Out_rb    = rb_q;

endmodule
